// File: rtl/tug_scoreboard_if.sv
// Player-side signal bundle for the tug-of-war scoreboard: press/edge-light
// inputs plus the three seven-segment digits and round/match status.
interface tug_if;
  logic       L;
  logic       R;
  logic       Le;
  logic       Re;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic [6:0] hex_win;
  logic       round_clr;
  logic       match_over;

  modport master (
    output L, R, Le, Re,
    input  hex_l, hex_r, hex_win, round_clr, match_over
  );

  modport slave (
    input  L, R, Le, Re,
    output hex_l, hex_r, hex_win, round_clr, match_over
  );
endinterface

// File: rtl/tug_scoreboard.sv
// Tug-of-war match scoreboard: counts round wins per side, holds the round
// winner on display, requests a playfield clear, and latches the match winner.
module tug_scoreboard #(
  parameter int WIN_TARGET  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  tug_if.slave bus
);
  localparam int         TW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_L   = 7'b0100100;
  localparam logic [6:0] GLYPH_R   = 7'b1111001;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {PLAY, ROUND_END, MATCH_OVER} state_e;

  state_e          state_q, state_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic [3:0]      score_nxt;
  logic [TW-1:0]   timer_q, timer_d;
  logic            winner_r_q, winner_r_d;
  logic            round_clr_q, round_clr_d;
  logic            match_over_q, match_over_d;
  logic [6:0]      hex_l_q, hex_l_d;
  logic [6:0]      hex_r_q, hex_r_d;
  logic [6:0]      hex_win_q, hex_win_d;
  logic            win_l, win_r;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // A simultaneous valid press from both sides cancels out.
  assign win_l = bus.Le && bus.L && !(bus.Re && bus.R);
  assign win_r = bus.Re && bus.R && !(bus.Le && bus.L);

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    timer_d     = timer_q;
    winner_r_d  = winner_r_q;
    round_clr_d = 1'b0;
    score_nxt   = win_l ? score_l_q + 4'd1 : score_r_q + 4'd1;

    case (state_q)
      PLAY: begin
        // The round_clr cycle belongs to the playfield reset, not to play.
        if (!round_clr_q && (win_l || win_r)) begin
          winner_r_d = win_r;
          if (win_l) score_l_d = score_nxt;
          else       score_r_d = score_nxt;
          timer_d = '0;
          state_d = (score_nxt == 4'(WIN_TARGET)) ? MATCH_OVER : ROUND_END;
        end
      end
      ROUND_END: begin
        if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          state_d     = PLAY;
          round_clr_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      MATCH_OVER: state_d = MATCH_OVER;
      default:    state_d = PLAY;
    endcase

    hex_l_d      = seg7(score_l_q);
    hex_r_d      = seg7(score_r_q);
    hex_win_d    = (state_d == PLAY) ? SEG_BLANK : (winner_r_d ? GLYPH_R : GLYPH_L);
    match_over_d = (state_d == MATCH_OVER);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= PLAY;
      score_l_q    <= '0;
      score_r_q    <= '0;
      timer_q      <= '0;
      winner_r_q   <= 1'b0;
      round_clr_q  <= 1'b0;
      match_over_q <= 1'b0;
      hex_l_q      <= SEG_ZERO;
      hex_r_q      <= SEG_ZERO;
      hex_win_q    <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      timer_q      <= timer_d;
      winner_r_q   <= winner_r_d;
      round_clr_q  <= round_clr_d;
      match_over_q <= match_over_d;
      hex_l_q      <= hex_l_d;
      hex_r_q      <= hex_r_d;
      hex_win_q    <= hex_win_d;
    end
  end

  assign bus.hex_l      = hex_l_q;
  assign bus.hex_r      = hex_r_q;
  assign bus.hex_win    = hex_win_q;
  assign bus.round_clr  = round_clr_q;
  assign bus.match_over = match_over_q;
endmodule

// File: tb/tb_tug_scoreboard.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge
// monitor pops and compares them against the three DUT configurations.
module tb_tug_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GL = 7'b0100100;
  localparam logic [6:0] GR = 7'b1111001;
  logic [6:0] dig [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  typedef struct {
    int         cyc;
    int         which;
    logic [6:0] hl, hr, hw;
    logic       rc, mo;
  } exp_t;
  exp_t q[$];

  tug_if ifa();
  tug_if ifb();
  tug_if ifc();

  tug_scoreboard #(.WIN_TARGET(3), .HOLD_CYCLES(4)) dut_a (.Clock(clk), .Reset(rst), .bus(ifa));
  tug_scoreboard #(.WIN_TARGET(1), .HOLD_CYCLES(1)) dut_b (.Clock(clk), .Reset(rst), .bus(ifb));
  tug_scoreboard #(.WIN_TARGET(2), .HOLD_CYCLES(1)) dut_c (.Clock(clk), .Reset(rst), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [6:0] hl, hr, hw;
      logic rc, mo;
      e = q.pop_front();
      case (e.which)
        0:       begin hl = ifa.hex_l; hr = ifa.hex_r; hw = ifa.hex_win; rc = ifa.round_clr; mo = ifa.match_over; end
        1:       begin hl = ifb.hex_l; hr = ifb.hex_r; hw = ifb.hex_win; rc = ifb.round_clr; mo = ifb.match_over; end
        default: begin hl = ifc.hex_l; hr = ifc.hex_r; hw = ifc.hex_win; rc = ifc.round_clr; mo = ifc.match_over; end
      endcase
      checks++;
      if (hl !== e.hl || hr !== e.hr || hw !== e.hw || rc !== e.rc || mo !== e.mo) begin
        errors++;
        $display("FAIL dut%0d cyc%0d: got hl=%b hr=%b hw=%b rc=%b mo=%b want hl=%b hr=%b hw=%b rc=%b mo=%b",
                 e.which, cyc, hl, hr, hw, rc, mo, e.hl, e.hr, e.hw, e.rc, e.mo);
      end
    end
  end

  task automatic drv(input logic r_, input logic l, input logic r, input logic le, input logic re);
    rst = r_;
    ifa.L = l; ifa.R = r; ifa.Le = le; ifa.Re = re;
    ifb.L = l; ifb.R = r; ifb.Le = le; ifb.Re = re;
    ifc.L = l; ifc.R = r; ifc.Le = le; ifc.Re = re;
    @(posedge clk); #1;
  endtask

  task automatic ex(input int which, input logic [6:0] hl, input logic [6:0] hr,
                    input logic [6:0] hw, input logic rc, input logic mo);
    exp_t e;
    e.cyc = cyc + 1; e.which = which;
    e.hl = hl; e.hr = hr; e.hw = hw; e.rc = rc; e.mo = mo;
    q.push_back(e);
  endtask

  // Drive one cycle on all DUTs and expect the given outputs from dut_a after the edge.
  task automatic t(input logic r_, input logic l, input logic r, input logic le, input logic re,
                   input logic [6:0] hl, input logic [6:0] hr, input logic [6:0] hw,
                   input logic rc, input logic mo);
    ex(0, hl, hr, hw, rc, mo);
    drv(r_, l, r, le, re);
  endtask

  initial begin
    ifa.L = 0; ifa.R = 0; ifa.Le = 0; ifa.Re = 0;
    ifb.L = 0; ifb.R = 0; ifb.Le = 0; ifb.Re = 0;
    ifc.L = 0; ifc.R = 0; ifc.Le = 0; ifc.Re = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    t(1, 0,0,0,0, dig[0], dig[0], BL, 0, 0);
    // Tie: both sides valid in the same cycle scores nothing
    t(0, 1,1,1,1, dig[0], dig[0], BL, 0, 0);
    t(0, 0,0,0,0, dig[0], dig[0], BL, 0, 0);
    // Left win, held 4 cycles with L pulses ignored during the hold
    t(0, 1,0,1,0, dig[0], dig[0], GL, 0, 0);
    t(0, 1,0,1,0, dig[1], dig[0], GL, 0, 0);
    t(0, 1,0,1,0, dig[1], dig[0], GL, 0, 0);
    t(0, 0,0,0,0, dig[1], dig[0], GL, 0, 0);
    t(0, 1,0,1,0, dig[1], dig[0], BL, 1, 0);
    // Press in the round_clr cycle is ignored
    t(0, 1,0,1,0, dig[1], dig[0], BL, 0, 0);
    t(0, 0,0,0,0, dig[1], dig[0], BL, 0, 0);
    // Two right round wins
    for (int k = 1; k <= 2; k++) begin
      t(0, 0,1,0,1, dig[1], dig[k-1], GR, 0, 0);
      repeat (3) t(0, 0,0,0,0, dig[1], dig[k], GR, 0, 0);
      t(0, 0,0,0,0, dig[1], dig[k], BL, 1, 0);
      t(0, 0,0,0,0, dig[1], dig[k], BL, 0, 0);
    end
    // Third right win takes the match; nothing moves afterwards
    t(0, 0,1,0,1, dig[1], dig[2], GR, 0, 1);
    t(0, 0,1,0,1, dig[1], dig[3], GR, 0, 1);
    t(0, 1,0,1,0, dig[1], dig[3], GR, 0, 1);
    repeat (5) t(0, 0,0,0,0, dig[1], dig[3], GR, 0, 1);
    // Reset out of MATCH_OVER, then reset mid-hold
    t(1, 0,0,0,0, dig[0], dig[0], BL, 0, 0);
    t(0, 1,0,1,0, dig[0], dig[0], GL, 0, 0);
    t(0, 0,0,0,0, dig[1], dig[0], GL, 0, 0);
    t(0, 0,0,0,0, dig[1], dig[0], GL, 0, 0);
    t(1, 1,0,1,0, dig[0], dig[0], BL, 0, 0);
    repeat (5) t(0, 0,0,0,0, dig[0], dig[0], BL, 0, 0);

    // Parameter sweep on dut_b (1,1) and dut_c (2,1)
    ex(1, dig[0], dig[0], BL, 0, 0); ex(2, dig[0], dig[0], BL, 0, 0); drv(1, 0,0,0,0);
    ex(1, dig[0], dig[0], GL, 0, 1); ex(2, dig[0], dig[0], GL, 0, 0); drv(0, 1,0,1,0);
    ex(1, dig[1], dig[0], GL, 0, 1); ex(2, dig[1], dig[0], BL, 1, 0); drv(0, 0,0,0,0);
    ex(1, dig[1], dig[0], GL, 0, 1); ex(2, dig[1], dig[0], BL, 0, 0); drv(0, 0,0,0,0);
    ex(1, dig[1], dig[0], GL, 0, 1); ex(2, dig[1], dig[0], GL, 0, 1); drv(0, 1,0,1,0);
    ex(1, dig[1], dig[0], GL, 0, 1); ex(2, dig[2], dig[0], GL, 0, 1); drv(0, 0,0,0,0);
    ex(1, dig[1], dig[0], GL, 0, 1); ex(2, dig[2], dig[0], GL, 0, 1); drv(0, 0,1,0,1);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tug_scoreboard.md
TUG_SCOREBOARD -- requirements
Module: tug_scoreboard

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match; legal range 1..9.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles the round winner is shown before the next round; legal range >= 1.
REQ-003 Port Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-005 Port L  input  1  left-player press, one-cycle pulse from upstream conditioning.
REQ-006 Port R  input  1  right-player press, one-cycle pulse.
REQ-007 Port Le  input  1  left edge light of the playfield is lit.
REQ-008 Port Re  input  1  right edge light of the playfield is lit.
REQ-009 Port hex_l  output  7  active-low seven-segment digit of the left score, bits [6:0] = g..a.
REQ-010 Port hex_r  output  7  active-low seven-segment digit of the right score, bits [6:0] = g..a.
REQ-011 Port hex_win  output  7  active-low winner glyph: 7'b0100100 ("2") for left, 7'b1111001 ("1") for right, 7'b1111111 blank.
REQ-012 Port round_clr  output  1  one-cycle pulse that requests a playfield reset for the next round.
REQ-013 Port match_over  output  1  high while the match is decided.

Function
REQ-014 The block SHALL implement three states: PLAY, ROUND_END and MATCH_OVER.
REQ-015 Left round win event SHALL be Le && L && !(Re && R); right event SHALL be Re && R && !(Le && L); both together SHALL score nothing.
REQ-016 Win events SHALL be accepted only in PLAY with round_clr low; inputs SHALL be ignored in all other cycles.
REQ-017 On an accepted event, the winner's score SHALL increment at that edge, and the winner (left/right) SHALL be latched.
REQ-018 On an accepted event, if the new score equals WIN_TARGET, the next state SHALL be MATCH_OVER; otherwise it SHALL be ROUND_END with the hold timer cleared to 0.
REQ-019 In ROUND_END the timer SHALL increment each cycle, and at the edge where timer == HOLD_CYCLES-1 the next state SHALL be PLAY with round_clr registered high for exactly the following cycle.
REQ-020 Timer width SHALL be $clog2(HOLD_CYCLES+1) bits; the timer SHALL never wrap.
REQ-021 hex_win SHALL show the latched winner glyph in ROUND_END and MATCH_OVER and SHALL be blank in PLAY.
REQ-022 match_over SHALL be high only in MATCH_OVER.
REQ-023 MATCH_OVER SHALL be absorbing until Reset; scores and hex_win SHALL hold.
REQ-024 hex_l and hex_r SHALL be the registered active-low encoding of scores 0..9, with "0" = 7'b1000000, "1" = 7'b1111001, "2" = 7'b0100100 and "3" = 7'b0110000; they SHALL update on the cycle after the score changes.
REQ-025 Scores SHALL be 4 bits and SHALL never exceed WIN_TARGET.

Reset
REQ-026 Reset SHALL take priority over every other input in every state, including mid-hold.
REQ-027 After Reset: state=PLAY, scores=0, timer=0, winner cleared, hex_l=hex_r=7'b1000000, hex_win=7'b1111111, round_clr=0, match_over=0.

Verification
REQ-028 Reset, then Le=1 with an L pulse -> score_l=1; hex_win=7'b0100100 for 4 cycles; round_clr high 1 cycle; then hex_win blank; hex_l="1".
REQ-029 Le=Re=1 with L and R pulsed in the same cycle -> no score change, state stays PLAY, hex_win stays blank.
REQ-030 L pulses during ROUND_END and during the round_clr cycle -> ignored; score_l unchanged.
REQ-031 Three right wins (Re&&R) -> after the third, match_over=1, hex_win=7'b1111001 and hex_r="3" (7'b0110000); further presses change nothing; round_clr is not pulsed.
REQ-032 Reset asserted on hold cycle 2 -> next cycle all outputs hold their REQ-027 values; no round_clr pulse.
REQ-033 Parameter sweep WIN_TARGET=1 and HOLD_CYCLES=1 -> the first win goes straight to MATCH_OVER; with WIN_TARGET=2, round_clr pulses exactly 1 cycle after the win.
